// File: rtl/hdmi_packet_serializer_if.sv
// Bundle between packet_picker and the data-island packet serializer.
// Ports: data_island_prepare/period, header, sub[3:0] toward the serializer;
//        packet_enable, packet_pixel_counter, packet_data(_valid), packet_truncated back out.
interface hdmi_packet_serializer_if;
  logic                  data_island_prepare;
  logic                  data_island_period;
  logic [23:0]           header;
  logic [3:0][55:0]      sub;
  logic                  packet_enable;
  logic [4:0]            packet_pixel_counter;
  logic [8:0]            packet_data;
  logic                  packet_data_valid;
  logic                  packet_truncated;

  // master: the side that supplies timing and packet contents
  modport master (
    output data_island_prepare, data_island_period, header, sub,
    input  packet_enable, packet_pixel_counter, packet_data, packet_data_valid, packet_truncated
  );

  // slave: the serializer itself
  modport slave (
    input  data_island_prepare, data_island_period, header, sub,
    output packet_enable, packet_pixel_counter, packet_data, packet_data_valid, packet_truncated
  );
endinterface

// File: rtl/hdmi_packet_serializer.sv
// Serializes one HDMI data-island packet (24-bit header + four 56-bit subpackets) over 32 pixels,
// appending BCH ECC bit-serially; emits 9 bits/pixel {odd sub3..0, even sub3..0, header bit}.
// Ports: clk_pixel, reset (async, active-high), bus (slave side of hdmi_packet_serializer_if).
module hdmi_packet_serializer #(
  parameter logic [7:0] ECC_POLY = 8'h83
) (
  input  logic                      clk_pixel,
  input  logic                      reset,
  hdmi_packet_serializer_if.slave   bus
);

  logic [4:0]       counter;
  logic             blocked;
  logic [23:0]      hdr_lat;
  logic [3:0][55:0] sub_lat;
  logic [7:0]       hecc;
  logic [3:0][7:0]  secc;
  logic [8:0]       data_q;
  logic             valid_q;
  logic             trunc_q;

  logic             run;
  logic             first;
  logic [23:0]      hdr_cur;
  logic [3:0][55:0] sub_cur;
  logic             hbit;
  logic [3:0]       even;
  logic [3:0]       odd;
  logic [7:0]       hecc_nxt;
  logic [3:0][7:0]  secc_nxt;

  function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
    logic [7:0] n;
    n = e ^ {7'b0, b};
    return n[0] ? ((n >> 1) ^ ECC_POLY) : (n >> 1);
  endfunction

  // After reset the serializer waits for the period to go low once, so a
  // packet can only start on a genuine rise of data_island_period.
  assign run   = bus.data_island_period & ~blocked;
  assign first = (counter == 5'd0);

  // In the counter==0 cycle the picker's outputs are used directly; afterwards
  // only the latched copy is valid.
  assign hdr_cur = first ? bus.header : hdr_lat;
  assign sub_cur = first ? bus.sub    : sub_lat;

  always_comb begin
    hbit     = 1'b0;
    even     = '0;
    odd      = '0;
    hecc_nxt = hecc;
    secc_nxt = secc;

    if (counter < 5'd24) begin
      hbit     = hdr_cur[counter];
      // ECC restarts from zero on the first pixel of every packet
      hecc_nxt = bch_step(first ? 8'h00 : hecc, hbit);
    end else begin
      // counter 24..31 -> ECC bit counter-24, which is simply counter[2:0]
      hbit = hecc[counter[2:0]];
    end

    for (int k = 0; k < 4; k++) begin
      if (counter < 5'd28) begin
        even[k]     = sub_cur[k][{counter, 1'b0}];
        odd[k]      = sub_cur[k][{counter, 1'b1}];
        secc_nxt[k] = bch_step(bch_step(first ? 8'h00 : secc[k], even[k]), odd[k]);
      end else begin
        // counter 28..31 -> ECC bit pair counter-28, i.e. counter[1:0]
        even[k] = secc[k][{counter[1:0], 1'b0}];
        odd[k]  = secc[k][{counter[1:0], 1'b1}];
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      counter <= '0;
      blocked <= 1'b1;
      hdr_lat <= '0;
      sub_lat <= '0;
      hecc    <= '0;
      secc    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      if (!bus.data_island_period) blocked <= 1'b0;

      if (run) begin
        counter <= counter + 5'd1;
        hecc    <= hecc_nxt;
        secc    <= secc_nxt;
        if (first) begin
          hdr_lat <= bus.header;
          sub_lat <= bus.sub;
        end
        data_q  <= {odd, even, hbit};
        valid_q <= 1'b1;
      end else begin
        counter <= '0;
        hecc    <= '0;
        secc    <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
      end

      // A nonzero counter with the period low means the island ended mid-packet
      trunc_q <= ~run & (counter != 5'd0);
    end
  end

  assign bus.packet_enable        = bus.data_island_prepare |
                                    (bus.data_island_period & (counter == 5'd31));
  assign bus.packet_pixel_counter = counter;
  assign bus.packet_data          = data_q;
  assign bus.packet_data_valid    = valid_q;
  assign bus.packet_truncated     = trunc_q;

endmodule

// File: tb/tb_hdmi_packet_serializer.sv
// Directed bench for hdmi_packet_serializer: hand-built vectors for zero / single-bit packets,
// a bit-serial BCH model for random back-to-back, truncated and reset-interrupted packets.
// Ports: none (drives the DUT through an instance of hdmi_packet_serializer_if).
module tb_hdmi_packet_serializer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hdmi_packet_serializer_if bus();

  hdmi_packet_serializer dut (
    .clk_pixel (clk),
    .reset     (reset),
    .bus       (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_w [32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
    logic [7:0] n;
    n = e ^ {7'b0, b};
    return {1'b0, n[7:1]} ^ (n[0] ? 8'h83 : 8'h00);
  endfunction

  // Reference: run the whole payload through the BCH shift register, append the
  // remainder, then slice the resulting streams into pixel words.
  task automatic build_exp(input logic [23:0] h, input logic [3:0][55:0] s);
    logic [7:0]  e;
    logic [31:0] hb;
    logic [63:0] sb [4];
    e = '0;
    for (int i = 0; i < 24; i++) e = ecc_step(e, h[i]);
    hb = {e, h};
    for (int k = 0; k < 4; k++) begin
      e = '0;
      for (int i = 0; i < 56; i++) e = ecc_step(e, s[k][i]);
      sb[k] = {e, s[k]};
    end
    for (int c = 0; c < 32; c++) begin
      exp_w[c][0] = hb[c];
      for (int k = 0; k < 4; k++) begin
        exp_w[c][1 + k] = sb[k][2 * c];
        exp_w[c][5 + k] = sb[k][2 * c + 1];
      end
    end
  endtask

  // cut_at <0: full packet; otherwise at that counter value either drop the period
  // or (use_reset) assert reset. Called at a falling edge.
  task automatic send_packet(input logic [23:0] h, input logic [3:0][55:0] s, input bit use_model,
                             input int cut_at, input bit use_reset, input bit last);
    if (use_model) build_exp(h, s);
    bus.data_island_period = 1'b1;
    bus.header = h;
    bus.sub    = s;
    for (int c = 0; c < 32; c++) begin
      if (c == cut_at) begin
        if (use_reset) begin
          reset = 1'b1;
          #1;
          chk("rst_data", bus.packet_data, 0);
          chk("rst_valid", bus.packet_data_valid, 0);
          chk("rst_counter", bus.packet_pixel_counter, 0);
        end else begin
          bus.data_island_period = 1'b0;
          #1;
          chk($sformatf("cut_data c%0d", c), bus.packet_data, exp_w[c-1]);
          chk("cut_counter", bus.packet_pixel_counter, c);
          @(negedge clk); #1;
          chk("trunc_pulse", bus.packet_truncated, 1);
          chk("trunc_counter", bus.packet_pixel_counter, 0);
          chk("trunc_valid", bus.packet_data_valid, 0);
          chk("trunc_data", bus.packet_data, 0);
          @(negedge clk); #1;
          chk("trunc_once", bus.packet_truncated, 0);
        end
        return;
      end
      if (c == 5) bus.data_island_prepare = 1'b1;
      #1;
      chk($sformatf("counter c%0d", c), bus.packet_pixel_counter, c);
      chk($sformatf("enable c%0d", c), bus.packet_enable, (c == 31) || (c == 5));
      if (c > 0) begin
        chk($sformatf("data c%0d", c - 1), bus.packet_data, exp_w[c-1]);
        chk($sformatf("valid c%0d", c - 1), bus.packet_data_valid, 1);
      end
      // picker outputs are only guaranteed at counter 0; scramble them afterwards
      if (c == 1) begin
        bus.header = 24'($urandom);
        bus.sub    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      bus.data_island_prepare = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("data c31", bus.packet_data, exp_w[31]);
    chk("valid c31", bus.packet_data_valid, 1);
    chk("no_trunc", bus.packet_truncated, 0);
    if (last) begin
      bus.data_island_period = 1'b0;
      @(negedge clk); #1;
      chk("end_valid", bus.packet_data_valid, 0);
      chk("end_data", bus.packet_data, 0);
      chk("end_trunc", bus.packet_truncated, 0);
      chk("end_counter", bus.packet_pixel_counter, 0);
    end
  endtask

  logic [23:0]      rh;
  logic [3:0][55:0] rs;

  initial begin
    reset = 1'b1;
    bus.data_island_prepare = 1'b0;
    bus.data_island_period  = 1'b0;
    bus.header = '0;
    bus.sub    = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_counter", bus.packet_pixel_counter, 0);
    chk("reset_data", bus.packet_data, 0);
    chk("reset_valid", bus.packet_data_valid, 0);
    chk("reset_trunc", bus.packet_truncated, 0);
    chk("reset_enable", bus.packet_enable, 0);
    reset = 1'b0;
    @(negedge clk);

    // all-zero packet
    bus.data_island_prepare = 1'b1;
    #1;
    chk("prepare_enable", bus.packet_enable, 1);
    @(negedge clk);
    bus.data_island_prepare = 1'b0;
    #1;
    chk("pre_valid", bus.packet_data_valid, 0);
    for (int c = 0; c < 32; c++) exp_w[c] = 9'h000;
    send_packet(24'h0, '0, 1'b0, -1, 1'b0, 1'b1);
    @(negedge clk);

    // header MSB only: bit at c23, then ECC 0x83 LSB-first
    for (int c = 0; c < 32; c++) exp_w[c] = 9'h000;
    exp_w[23] = 9'h001; exp_w[24] = 9'h001; exp_w[25] = 9'h001; exp_w[31] = 9'h001;
    send_packet(24'h800000, '0, 1'b0, -1, 1'b0, 1'b1);
    @(negedge clk);

    // sub[2] MSB only: odd bit of sub2 lands on bit 7, even on bit 3
    for (int c = 0; c < 32; c++) exp_w[c] = 9'h000;
    exp_w[27] = 9'h080; exp_w[28] = 9'h088; exp_w[31] = 9'h080;
    rs = '0;
    rs[2] = 56'h80_0000_0000_0000;
    send_packet(24'h0, rs, 1'b0, -1, 1'b0, 1'b1);
    @(negedge clk);

    // two back-to-back random packets
    rh = 24'($urandom);
    rs = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_packet(rh, rs, 1'b1, -1, 1'b0, 1'b0);
    rh = 24'($urandom);
    rs = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_packet(rh, rs, 1'b1, -1, 1'b0, 1'b1);
    @(negedge clk);

    // island ends at counter 13, then a clean packet
    rh = 24'($urandom);
    rs = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_packet(rh, rs, 1'b1, 13, 1'b0, 1'b0);
    rh = 24'($urandom);
    rs = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_packet(rh, rs, 1'b1, -1, 1'b0, 1'b1);
    @(negedge clk);

    // reset at counter 20; period stays high across reset and must be ignored
    rh = 24'($urandom);
    rs = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_packet(rh, rs, 1'b1, 20, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst_valid", bus.packet_data_valid, 0);
    chk("post_rst_counter", bus.packet_pixel_counter, 0);
    chk("post_rst_trunc", bus.packet_truncated, 0);
    bus.data_island_period = 1'b0;
    @(negedge clk);
    rh = 24'($urandom);
    rs = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_packet(rh, rs, 1'b1, -1, 1'b0, 1'b1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
